// File: rtl/fetch_unit_if.sv
// Instruction-memory read channel between the fetch unit and instruction memory.
// The fetch unit is the master: it raises imem_req with a stable address and
// waits for imem_ack, which carries imem_data in the same cycle.
interface fetch_unit_if #(
    parameter int AW = 8
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [15:0]   imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch / program-counter stage. Fetches one 16-bit instruction
// per visit to FETCH, presents its fields during EXEC and, when the
// instruction commits, selects the next PC: increment, conditional
// PC-relative branch on Z or N, or register jump.
module fetch_unit #(
    parameter int          AW       = 8,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_unit_if.master  imem,
    output logic [6:0]    opcode,
    output logic [2:0]    dr,
    output logic [2:0]    sa,
    output logic [2:0]    sb,
    output logic          valid,
    output logic [AW-1:0] pc,
    input  logic          pl,
    input  logic          jb,
    input  logic          bc,
    input  logic          flag_z,
    input  logic          flag_n,
    input  logic [AW-1:0] jump_target,
    input  logic          stall
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [15:0]   ir_q, ir_d;

    logic [5:0]    ad;
    logic [AW-1:0] ad_se;
    logic [AW-1:0] pc_inc;
    logic [AW-1:0] pc_branch;
    logic [AW-1:0] next_pc;
    logic          branch_taken;

    // Branch displacement {dr,sb} comes straight from the IR, so it is stable
    // for the whole EXEC phase; the signed cast sign-extends to AW bits.
    assign ad        = {ir_q[8:6], ir_q[2:0]};
    assign ad_se     = AW'($signed(ad));
    assign pc_inc    = pc_q + AW'(1);
    assign pc_branch = pc_q + ad_se;

    // Next-PC selection; all sums wrap modulo 2^AW by construction.
    always_comb begin
        branch_taken = 1'b0;
        next_pc      = pc_inc;
        if (pl) begin
            if (jb) begin
                next_pc = jump_target;
            end else begin
                branch_taken = bc ? flag_n : flag_z;
                next_pc      = branch_taken ? pc_branch : pc_inc;
            end
        end
    end

    // State, PC and IR registers; reset also kills any outstanding read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state and handshake/valid outputs; stall and ack are only looked
    // at in the states where they mean something.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ir_d          = ir_q;
        imem.imem_req = 1'b0;
        valid         = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                imem.imem_req = 1'b1;
                if (imem.imem_ack) begin
                    ir_d    = imem.imem_data;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                valid = 1'b1;
                if (!stall) begin
                    pc_d    = next_pc;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The address only changes on commit, so it is stable across ack waits.
    assign imem.imem_addr = pc_q;
    assign pc             = pc_q;
    assign opcode         = ir_q[15:9];
    assign dr             = ir_q[8:6];
    assign sa             = ir_q[5:3];
    assign sb             = ir_q[2:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: reset, sequential fetch with ack
// latencies, BZ/BN branches, register jump, stall and PC wrap.
module tb_fetch_unit;

    localparam int AW = 8;

    logic          clk;
    logic          rst_n;
    logic [6:0]    opcode;
    logic [2:0]    dr, sa, sb;
    logic          valid;
    logic [AW-1:0] pc;
    logic          pl, jb, bc, flag_z, flag_n, stall;
    logic [AW-1:0] jump_target;

    int tests;
    int fails;

    fetch_unit_if #(.AW(AW)) imem_bus ();

    fetch_unit #(.AW(AW), .RESET_PC(8'h00)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem        (imem_bus),
        .opcode      (opcode),
        .dr          (dr),
        .sa          (sa),
        .sb          (sb),
        .valid       (valid),
        .pc          (pc),
        .pl          (pl),
        .jb          (jb),
        .bc          (bc),
        .flag_z      (flag_z),
        .flag_n      (flag_n),
        .jump_target (jump_target),
        .stall       (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        tests++;
        if (imem_bus.imem_req !== 1'b0 || valid !== 1'b0 || pc !== 8'h00) begin
            fails++;
            $display("FAIL reset_initial: req=%b valid=%b pc=%h, want req=0 valid=0 pc=00",
                     imem_bus.imem_req, valid, pc);
        end
        rst_n = 1'b1;
        tick();
        tests++;
        if (imem_bus.imem_req !== 1'b1) begin
            fails++;
            $display("FAIL reset_first_fetch: req=%b, want 1", imem_bus.imem_req);
        end
        // assert reset asynchronously in the middle of a FETCH cycle
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (imem_bus.imem_req !== 1'b0 || valid !== 1'b0 || pc !== 8'h00) begin
            fails++;
            $display("FAIL reset_async: req=%b valid=%b pc=%h, want req=0 valid=0 pc=00",
                     imem_bus.imem_req, valid, pc);
        end
        tick();
        tick();
        tests++;
        if (imem_bus.imem_req !== 1'b0 || valid !== 1'b0 || pc !== 8'h00) begin
            fails++;
            $display("FAIL reset_hold: req=%b valid=%b pc=%h, want req=0 valid=0 pc=00",
                     imem_bus.imem_req, valid, pc);
        end
        rst_n = 1'b1;
        #1;
        tests++;
        if (imem_bus.imem_req !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: req=%b, want 0 during IDLE", imem_bus.imem_req);
        end
        tick();
        tests++;
        if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 8'h00) begin
            fails++;
            $display("FAIL reset_release: req=%b addr=%h, want req=1 addr=00",
                     imem_bus.imem_req, imem_bus.imem_addr);
        end
        $display("[TB] reset: req=%b addr=%h", imem_bus.imem_req, imem_bus.imem_addr);
    endtask

    // Serve one fetch at exp_addr after lat wait cycles, then check the IR.
    task automatic fetch(input logic [AW-1:0] exp_addr, input int lat, input logic [15:0] word);
        int waited;
        waited = 0;
        while (imem_bus.imem_req !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        tests++;
        if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== exp_addr) begin
            fails++;
            $display("FAIL fetch_addr: req=%b addr=%h, want req=1 addr=%h",
                     imem_bus.imem_req, imem_bus.imem_addr, exp_addr);
        end
        for (int i = 0; i < lat; i++) begin
            imem_bus.imem_ack = 1'b0;
            tick();
            tests++;
            if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== exp_addr || valid !== 1'b0) begin
                fails++;
                $display("FAIL fetch_wait: req=%b addr=%h valid=%b, want req=1 addr=%h valid=0",
                         imem_bus.imem_req, imem_bus.imem_addr, valid, exp_addr);
            end
        end
        imem_bus.imem_ack  = 1'b1;
        imem_bus.imem_data = word;
        tick();
        imem_bus.imem_ack  = 1'b0;
        imem_bus.imem_data = 16'hDEAD;
        tests++;
        if (valid !== 1'b1 || imem_bus.imem_req !== 1'b0 || pc !== exp_addr ||
            opcode !== word[15:9] || dr !== word[8:6] || sa !== word[5:3] || sb !== word[2:0]) begin
            fails++;
            $display("FAIL exec_ir: valid=%b req=%b pc=%h fields=%h/%h/%h/%h, want 1/0/%h %h/%h/%h/%h",
                     valid, imem_bus.imem_req, pc, opcode, dr, sa, sb,
                     exp_addr, word[15:9], word[8:6], word[5:3], word[2:0]);
        end
        $display("[TB] fetch addr=%h lat=%0d word=%h", exp_addr, lat, word);
    endtask

    // Commit the EXEC instruction after nstall stall cycles.
    task automatic exec(input logic p, input logic j, input logic b, input logic z,
                        input logic n, input logic [AW-1:0] jt, input int nstall);
        logic [AW-1:0] pc_hold;
        logic [6:0]    op_hold;
        pc_hold = pc;
        op_hold = opcode;
        for (int i = 0; i < nstall; i++) begin
            // decoder inputs during a stall must be ignored
            stall = 1'b1; pl = 1'b1; jb = 1'b1; jump_target = 8'h55;
            tick();
            tests++;
            if (valid !== 1'b1 || pc !== pc_hold || opcode !== op_hold || imem_bus.imem_req !== 1'b0) begin
                fails++;
                $display("FAIL stall_hold: valid=%b pc=%h op=%h req=%b, want 1 %h %h 0",
                         valid, pc, opcode, imem_bus.imem_req, pc_hold, op_hold);
            end
        end
        stall = 1'b0; pl = p; jb = j; bc = b; flag_z = z; flag_n = n; jump_target = jt;
        tick();
        pl = 1'b0; jb = 1'b0; bc = 1'b0; flag_z = 1'b0; flag_n = 1'b0; jump_target = 8'h00;
        tests++;
        if (valid !== 1'b0 || imem_bus.imem_req !== 1'b1) begin
            fails++;
            $display("FAIL commit: valid=%b req=%b, want valid=0 req=1", valid, imem_bus.imem_req);
        end
        $display("[TB] exec pl=%b jb=%b bc=%b z=%b n=%b stall=%0d -> addr=%h",
                 p, j, b, z, n, nstall, imem_bus.imem_addr);
    endtask

    task automatic test_sequential();
        fetch(8'h00, 0, 16'h0201); exec(0, 0, 0, 0, 0, 8'h00, 0);
        fetch(8'h01, 3, 16'h0452); exec(0, 0, 0, 1, 1, 8'h77, 0);
        fetch(8'h02, 1, 16'h06A3); exec(0, 0, 0, 0, 0, 8'h00, 0);
        fetch(8'h03, 0, 16'hE000); exec(1, 1, 0, 0, 0, 8'h05, 0);
    endtask

    task automatic test_bz();
        // dr=111 sb=110 -> AD=-2
        fetch(8'h05, 0, {7'h20, 3'b111, 3'b010, 3'b110}); exec(1, 0, 0, 1, 0, 8'h00, 0);
        fetch(8'h03, 0, 16'hE000); exec(1, 1, 0, 0, 0, 8'h05, 0);
        fetch(8'h05, 0, {7'h20, 3'b111, 3'b010, 3'b110}); exec(1, 0, 0, 0, 1, 8'h00, 0);
        fetch(8'h06, 0, 16'hE000); exec(1, 1, 0, 0, 0, 8'h10, 0);
    endtask

    task automatic test_bn();
        // dr=000 sb=011 -> AD=+3
        fetch(8'h10, 0, {7'h21, 3'b000, 3'b101, 3'b011}); exec(1, 0, 1, 0, 1, 8'h00, 0);
        fetch(8'h13, 0, 16'hE000); exec(1, 1, 0, 0, 0, 8'h10, 0);
        fetch(8'h10, 0, {7'h21, 3'b000, 3'b101, 3'b011}); exec(1, 0, 1, 1, 0, 8'h00, 0);
    endtask

    task automatic test_jump();
        fetch(8'h11, 2, 16'hE008); exec(1, 1, 0, 0, 0, 8'hA5, 0);
        fetch(8'hA5, 0, 16'hE008); exec(1, 1, 0, 0, 0, 8'hFF, 0);
    endtask

    task automatic test_stall_wrap();
        fetch(8'hFF, 0, 16'h1234); exec(0, 0, 0, 0, 0, 8'h00, 2);
        fetch(8'h00, 0, 16'h0000); exec(0, 0, 0, 0, 0, 8'h00, 0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        imem_bus.imem_ack  = 1'b0;
        imem_bus.imem_data = 16'h0000;
        pl = 1'b0; jb = 1'b0; bc = 1'b0; flag_z = 1'b0; flag_n = 1'b0;
        stall = 1'b0; jump_target = 8'h00;

        test_reset();
        test_sequential();
        test_bz();
        test_bn();
        test_jump();
        test_stall_wrap();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch and program-counter stage that feeds the instruction decoder of the single-cycle CPU. It holds the PC and issues instruction-memory reads over a req/ack handshake. It latches each 16-bit instruction into an instruction register and presents its fields to the decoder. It then uses the decoder's PL/JB/BC outputs and the datapath's Z/N flags to choose the next PC: increment, conditional PC-relative branch, or register jump.

## Interface
- AW, 8, PC / instruction-address width; legal range 6..16.
- RESET_PC, 0, PC value loaded on reset.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  instruction read request.
- imem_addr  out  AW  read address; equals pc while imem_req=1.
- imem_ack  in  1  read complete; imem_data valid in the same cycle.
- imem_data  in  16  instruction word {opcode[6:0], dr[2:0], sa[2:0], sb[2:0]}.
- opcode  out  7  IR[15:9].
- dr  out  3  IR[8:6].
- sa  out  3  IR[5:3].
- sb  out  3  IR[2:0].
- valid  out  1  IR holds an instruction that executes this cycle.
- pc  out  AW  address of the instruction in IR (and of the pending fetch during FETCH).
- pl, jb, bc  in  1 each  decoder outputs for the current IR.
- flag_z, flag_n  in  1 each  zero/negative flags of the current instruction's function-unit result.
- jump_target  in  AW  R[SA] value from the register file, used when pl=1 and jb=1.
- stall  in  1  hold the current instruction in EXEC.

## Operation
- States: IDLE, FETCH, EXEC.
- Reset values: state=IDLE, pc=RESET_PC, IR=16'h0000, imem_req=0, valid=0. Reset applies asynchronously and drops imem_req immediately; any outstanding read is abandoned.
- IDLE: lasts one cycle after reset release, then goes to FETCH.
- FETCH:
  - imem_req=1 and imem_addr=pc, both held stable until ack.
  - On a clock edge with imem_ack=1: IR<=imem_data, then go to EXEC.
  - imem_ack=0: stay in FETCH.
- EXEC:
  - valid=1 and imem_req=0.
  - stall=1: hold state, pc and IR; valid stays 1.
  - stall=0: the instruction commits at this edge. pc<=next_pc, then go to FETCH.
- next_pc, with AD={dr,sb} (6 bits) sign-extended to AW bits:
  - pl=1, jb=1: jump_target.
  - pl=1, jb=0, bc=0: pc+se(AD) if flag_z=1, else pc+1.
  - pl=1, jb=0, bc=1: pc+se(AD) if flag_n=1, else pc+1.
  - pl=0: pc+1.
- Arithmetic is modulo 2^AW. All-ones+1 wraps to 0; negative offsets wrap below 0.
- Ignored inputs:
  - imem_ack outside FETCH.
  - stall outside EXEC.
  - pl/jb/bc/flags/jump_target outside EXEC and while stall=1.

## Timing
- Minimum 2 cycles per instruction: one FETCH cycle with immediate ack, plus one EXEC cycle. Each ack-wait cycle adds one cycle; each stall cycle adds one cycle.
- The opcode/dr/sa/sb fields change only on the edge that leaves FETCH. They are stable throughout EXEC, so the combinational decoder outputs are stable too.
- pl/jb/bc and the flags are sampled on the committing EXEC edge only.
- The next imem_req rises in the cycle after commit, carrying the new pc.
- imem_req never asserts in IDLE or EXEC.

## Test plan
- Reset: hold rst_n=0 mid-FETCH, then release.
  - While reset is low: imem_req=0, valid=0, pc=RESET_PC.
  - After release: one IDLE cycle, then imem_req=1 with imem_addr=0.
- Sequential fetch with ack latencies of 0, 3 and 1 cycles, and pl=0.
  - Addresses 0, 1, 2 are fetched.
  - valid pulses high for exactly one cycle per instruction.
  - imem_addr is stable throughout each wait.
- BZ at pc=5 with pl=1, jb=0, bc=0, dr=3'b111, sb=3'b110 (AD=-2).
  - flag_z=1: next fetch address is 3.
  - Repeat with flag_z=0: next fetch address is 6.
- BN at pc=8'h10 with bc=1, AD=6'b000011.
  - flag_n=1: next fetch address is 8'h13.
  - flag_n=0, even with flag_z=1: next fetch address is 8'h11.
- Jump with pl=1, jb=1, jump_target=8'hA5: next imem_addr=8'hA5.
- Stall and wrap at pc=8'hFF with pl=0: assert stall for 2 EXEC cycles.
  - valid, IR and pc are held for 3 cycles in total.
  - Next fetch address is 8'h00.
